alu_issue_queue: RTL

- Reservation station and issue stage feeding the ALU execute stage.
- Holds up to DEPTH dispatched ALU ops and captures source operands from the common data bus (CDB).
- Each cycle, selects the oldest ready op and drives the ALU request bundle from registers.
- Generates the ALU-bypass source-mux code so a dependent op can issue back-to-back with its producer.

---
 rtl/alu_iq_pkg.sv | 40 ++++
 rtl/iq_select.sv | 27 ++
 rtl/alu_issue_queue.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_iq_pkg.sv
// Shared definitions for the ALU issue queue: ALU source-mux codes, the queue
// entry payload, and small operand-usage helpers.
package alu_iq_pkg;

    localparam logic [2:0] SRC1_RS     = 3'b000;
    localparam logic [2:0] SRC1_PC     = 3'b001;
    localparam logic [2:0] SRC1_ZERO   = 3'b010;
    localparam logic [2:0] SRC1_ALUBYP = 3'b100;
    localparam logic [2:0] SRC1_JMPBYP = 3'b110;

    localparam logic [2:0] SRC2_RS     = 3'b000;
    localparam logic [2:0] SRC2_SIMM   = 3'b001;
    localparam logic [2:0] SRC2_SHAMT  = 3'b010;
    localparam logic [2:0] SRC2_UPPER  = 3'b011;
    localparam logic [2:0] SRC2_ALUBYP = 3'b100;

    // Tags are kept outside the struct so TAG_W can remain a module parameter.
    typedef struct packed {
        logic        valid;
        logic [2:0]  funct3;
        logic [1:0]  op_mux;
        logic [2:0]  src1_sel;
        logic [2:0]  src2_sel;
        logic        rs1_rdy;
        logic        rs2_rdy;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] pc;
        logic [19:0] imm;
    } iq_entry_t;

    function automatic logic src1_uses_reg(input logic [2:0] sel);
        return (sel == SRC1_RS);
    endfunction

    function automatic logic src2_uses_reg(input logic [2:0] sel);
        return (sel == SRC2_RS);
    endfunction

endpackage

// File: rtl/iq_select.sv
// Oldest-first priority picker: grants the lowest-index requesting entry.
module iq_select #(
    parameter int DEPTH = 4,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0] req,
    output logic [DEPTH-1:0] grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic found_s;

    // Ascending scan; once a request is seen every younger entry is masked
    always_comb begin
        found_s = 1'b0;
        grant   = '0;
        idx     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            grant[i] = req[i] && !found_s;
            idx      = grant[i] ? IDX_W'(i) : idx;
            found_s  = found_s | req[i];
        end
        any = found_s;
    end

endmodule

// File: rtl/alu_issue_queue.sv
// ALU reservation station: collapsing oldest-first queue with CDB wakeup,
// ALU-bypass aware selection and a registered ALU request bundle.
module alu_issue_queue
    import alu_iq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             disp_valid,
    output logic             disp_ready,
    input  logic [2:0]       disp_funct3,
    input  logic [1:0]       disp_op_mux,
    input  logic [2:0]       disp_src1_sel,
    input  logic [2:0]       disp_src2_sel,
    input  logic             disp_rs1_rdy,
    input  logic             disp_rs2_rdy,
    input  logic [TAG_W-1:0] disp_rs1_tag,
    input  logic [TAG_W-1:0] disp_rs2_tag,
    input  logic [31:0]      disp_rs1_data,
    input  logic [31:0]      disp_rs2_data,
    input  logic [31:0]      disp_pc,
    input  logic [19:0]      disp_imm,
    input  logic [TAG_W-1:0] disp_dst_tag,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [31:0]      cdb_data,
    output logic             req_ex,
    output logic [2:0]       funct3_ex,
    output logic [1:0]       op_mux,
    output logic [2:0]       src1_mux,
    output logic [2:0]       src2_mux,
    output logic [31:0]      datars1_ex_alu,
    output logic [31:0]      datars2_ex_alu,
    output logic [31:0]      pc_ex,
    output logic [19:0]      imm,
    output logic [TAG_W-1:0] dst_tag_ex
);

    localparam int IDX_W = $clog2(DEPTH);

    iq_entry_t        q_r       [DEPTH];
    logic [TAG_W-1:0] tag1_r    [DEPTH];
    logic [TAG_W-1:0] tag2_r    [DEPTH];
    logic [TAG_W-1:0] dtag_r    [DEPTH];
    iq_entry_t        q_nx_s    [DEPTH];
    logic [TAG_W-1:0] tag1_nx_s [DEPTH];
    logic [TAG_W-1:0] tag2_nx_s [DEPTH];
    logic [TAG_W-1:0] dtag_nx_s [DEPTH];

    logic [DEPTH-1:0] cdb1_s, cdb2_s, byp1_s, byp2_s, rdy_s, grant_s;
    logic [IDX_W-1:0] sel_idx_s;
    logic             sel_any_s;
    logic             disp_fire_s;
    iq_entry_t        disp_e_s;
    iq_entry_t        sel_e_s;
    logic [2:0]       src1_nx_s, src2_nx_s;
    logic [31:0]      d1_nx_s, d2_nx_s;

    // Collapsing queue: full exactly when the last slot is occupied
    assign disp_ready  = !q_r[DEPTH-1].valid;
    assign disp_fire_s = disp_valid && disp_ready;

    // Per-entry wakeup terms; a live CDB match or ALU bypass counts as ready
    always_comb begin
        cdb1_s = '0;
        cdb2_s = '0;
        byp1_s = '0;
        byp2_s = '0;
        rdy_s  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cdb1_s[i] = cdb_valid && !q_r[i].rs1_rdy && (tag1_r[i] == cdb_tag);
            cdb2_s[i] = cdb_valid && !q_r[i].rs2_rdy && (tag2_r[i] == cdb_tag);
            byp1_s[i] = req_ex && !q_r[i].rs1_rdy && (tag1_r[i] == dst_tag_ex);
            byp2_s[i] = req_ex && !q_r[i].rs2_rdy && (tag2_r[i] == dst_tag_ex);
            rdy_s[i]  = q_r[i].valid
                        && (q_r[i].rs1_rdy || cdb1_s[i] || byp1_s[i])
                        && (q_r[i].rs2_rdy || cdb2_s[i] || byp2_s[i]);
        end
    end

    iq_select #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_select (
        .req   (rdy_s),
        .grant (grant_s),
        .idx   (sel_idx_s),
        .any   (sel_any_s)
    );

    // Operand source for the selected entry: captured > CDB forward > ALU bypass
    always_comb begin
        sel_e_s   = q_r[sel_idx_s];
        src1_nx_s = sel_e_s.src1_sel;
        d1_nx_s   = sel_e_s.rs1_data;
        src2_nx_s = sel_e_s.src2_sel;
        d2_nx_s   = sel_e_s.rs2_data;
        if (sel_e_s.rs1_rdy) begin
            src1_nx_s = sel_e_s.src1_sel;
            d1_nx_s   = sel_e_s.rs1_data;
        end else if (cdb1_s[sel_idx_s]) begin
            src1_nx_s = SRC1_RS;
            d1_nx_s   = cdb_data;
        end else begin
            src1_nx_s = SRC1_ALUBYP;
            d1_nx_s   = 32'd0;
        end
        if (sel_e_s.rs2_rdy) begin
            src2_nx_s = sel_e_s.src2_sel;
            d2_nx_s   = sel_e_s.rs2_data;
        end else if (cdb2_s[sel_idx_s]) begin
            src2_nx_s = SRC2_RS;
            d2_nx_s   = cdb_data;
        end else begin
            src2_nx_s = SRC2_ALUBYP;
            d2_nx_s   = 32'd0;
        end
    end

    // New entry: unused operands are ready, pending ones may catch the CDB now
    always_comb begin
        disp_e_s          = '0;
        disp_e_s.valid    = 1'b1;
        disp_e_s.funct3   = disp_funct3;
        disp_e_s.op_mux   = disp_op_mux;
        disp_e_s.src1_sel = disp_src1_sel;
        disp_e_s.src2_sel = disp_src2_sel;
        disp_e_s.pc       = disp_pc;
        disp_e_s.imm      = disp_imm;
        if (disp_rs1_rdy || !src1_uses_reg(disp_src1_sel)) begin
            disp_e_s.rs1_rdy  = 1'b1;
            disp_e_s.rs1_data = disp_rs1_data;
        end else if (cdb_valid && (disp_rs1_tag == cdb_tag)) begin
            disp_e_s.rs1_rdy  = 1'b1;
            disp_e_s.rs1_data = cdb_data;
        end else begin
            disp_e_s.rs1_rdy  = 1'b0;
            disp_e_s.rs1_data = disp_rs1_data;
        end
        if (disp_rs2_rdy || !src2_uses_reg(disp_src2_sel)) begin
            disp_e_s.rs2_rdy  = 1'b1;
            disp_e_s.rs2_data = disp_rs2_data;
        end else if (cdb_valid && (disp_rs2_tag == cdb_tag)) begin
            disp_e_s.rs2_rdy  = 1'b1;
            disp_e_s.rs2_data = cdb_data;
        end else begin
            disp_e_s.rs2_rdy  = 1'b0;
            disp_e_s.rs2_data = disp_rs2_data;
        end
    end

    // Next queue image: collapse over the issued slot, CDB capture, tail append
    always_comb begin
        logic carry_v;
        logic placed_v;
        logic cap1_v;
        logic cap2_v;
        int   src_v;
        carry_v  = 1'b0;
        placed_v = 1'b0;
        cap1_v   = 1'b0;
        cap2_v   = 1'b0;
        src_v    = 0;
        for (int j = 0; j < DEPTH; j++) begin
            carry_v = carry_v | grant_s[j];
            if (carry_v && (j < DEPTH - 1)) begin
                src_v = j + 1;
            end else begin
                src_v = j;
            end
            q_nx_s[j]       = q_r[src_v];
            tag1_nx_s[j]    = tag1_r[src_v];
            tag2_nx_s[j]    = tag2_r[src_v];
            dtag_nx_s[j]    = dtag_r[src_v];
            q_nx_s[j].valid = q_r[src_v].valid && !(carry_v && (j == DEPTH - 1));

            cap1_v = cdb_valid && !q_nx_s[j].rs1_rdy && (tag1_nx_s[j] == cdb_tag);
            cap2_v = cdb_valid && !q_nx_s[j].rs2_rdy && (tag2_nx_s[j] == cdb_tag);
            q_nx_s[j].rs1_rdy  = q_nx_s[j].rs1_rdy | cap1_v;
            q_nx_s[j].rs1_data = cap1_v ? cdb_data : q_nx_s[j].rs1_data;
            q_nx_s[j].rs2_rdy  = q_nx_s[j].rs2_rdy | cap2_v;
            q_nx_s[j].rs2_data = cap2_v ? cdb_data : q_nx_s[j].rs2_data;

            if (disp_fire_s && !placed_v && !q_nx_s[j].valid) begin
                q_nx_s[j]    = disp_e_s;
                tag1_nx_s[j] = disp_rs1_tag;
                tag2_nx_s[j] = disp_rs2_tag;
                dtag_nx_s[j] = disp_dst_tag;
                placed_v     = 1'b1;
            end else begin
                placed_v     = placed_v;
            end
        end
    end

    // Queue state and registered ALU request bundle
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            for (int j = 0; j < DEPTH; j++) begin
                q_r[j]    <= '0;
                tag1_r[j] <= '0;
                tag2_r[j] <= '0;
                dtag_r[j] <= '0;
            end
            req_ex         <= 1'b0;
            funct3_ex      <= 3'd0;
            op_mux         <= 2'd0;
            src1_mux       <= 3'd0;
            src2_mux       <= 3'd0;
            datars1_ex_alu <= 32'd0;
            datars2_ex_alu <= 32'd0;
            pc_ex          <= 32'd0;
            imm            <= 20'd0;
            dst_tag_ex     <= '0;
        end else begin
            for (int j = 0; j < DEPTH; j++) begin
                q_r[j]    <= q_nx_s[j];
                tag1_r[j] <= tag1_nx_s[j];
                tag2_r[j] <= tag2_nx_s[j];
                dtag_r[j] <= dtag_nx_s[j];
            end
            req_ex <= sel_any_s;
            if (sel_any_s) begin
                funct3_ex      <= sel_e_s.funct3;
                op_mux         <= sel_e_s.op_mux;
                src1_mux       <= src1_nx_s;
                src2_mux       <= src2_nx_s;
                datars1_ex_alu <= d1_nx_s;
                datars2_ex_alu <= d2_nx_s;
                pc_ex          <= sel_e_s.pc;
                imm            <= sel_e_s.imm;
                dst_tag_ex     <= dtag_r[sel_idx_s];
            end
        end
    end

endmodule
